// File: rtl/minterm_func_gen.sv
// Minterm function generator: one-hot decoder feeding N_FUNC run-time programmable
// OR-of-minterm outputs, plus a sweep mode that walks every input code for truth-table readout.
module minterm_func_gen #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_FUNC = 3,
  localparam int unsigned SW    = (N_FUNC > 1) ? $clog2(N_FUNC) : 1,
  localparam int unsigned DW    = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SW-1:0]     cfg_sel,
  input  logic [DW-1:0]     cfg_mask,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              out_valid,
  output logic [N_IN-1:0]   out_idx,
  output logic [DW-1:0]     dec,
  output logic [N_FUNC-1:0] f
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [N_IN-1:0]   cnt;
  logic [N_IN-1:0]   cnt_next;

  logic              inj_valid;
  logic [N_IN-1:0]   inj_code;
  logic [DW-1:0]     inj_dec;

  logic              cfg_fire;
  logic              sel_ok;
  logic [DW-1:0]     masks [N_FUNC];

  logic              s1_valid;
  logic [N_IN-1:0]   s1_code;
  logic [DW-1:0]     s1_dec;

  logic              s2_valid;
  logic [N_IN-1:0]   s2_code;
  logic [DW-1:0]     s2_dec;
  logic [N_FUNC-1:0] s2_f;
  logic [N_FUNC-1:0] hit;

  // Both ports are closed for the whole sweep so masks stay stable across it.
  assign sweep_busy = (state == SWEEP);
  assign cfg_ready  = ~sweep_busy;
  assign in_ready   = ~sweep_busy;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign sel_ok   = (32'(cfg_sel) < N_FUNC);

  // Sweep FSM state and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and injection source select.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    inj_valid  = 1'b0;
    inj_code   = in_data;
    case (state)
      IDLE: begin
        inj_valid = in_valid;
        if (sweep_start) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        inj_valid = 1'b1;
        inj_code  = cnt;
        cnt_next  = cnt + N_IN'(1);
        if (cnt == N_IN'(DW - 1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot decode of the injected code.
  always_comb begin
    inj_dec = '0;
    for (int m = 0; m < int'(DW); m++) begin
      inj_dec[m] = (inj_code == N_IN'(m));
    end
  end

  // Mask storage and out-of-range write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_FUNC); i++) begin
        masks[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire & ~sel_ok;
      for (int i = 0; i < int'(N_FUNC); i++) begin
        if (cfg_fire && sel_ok && (cfg_sel == SW'(i))) begin
          masks[i] <= cfg_mask;
        end
      end
    end
  end

  // Minterm match per function against the pre-edge mask.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(N_FUNC); i++) begin
      hit[i] = |(s1_dec & masks[i]);
    end
  end

  // S1: capture code and decode at the injection edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_dec   <= '0;
    end else begin
      s1_valid <= inj_valid;
      if (inj_valid) begin
        s1_code <= inj_code;
        s1_dec  <= inj_dec;
      end
    end
  end

  // S2: apply masks one edge after injection, so a write on that edge is not yet seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_code  <= '0;
      s2_dec   <= '0;
      s2_f     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_code <= s1_code;
        s2_dec  <= s1_dec;
        s2_f    <= hit;
      end
    end
  end

  // Output register; data holds between valid items.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      dec       <= '0;
      f         <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_idx <= s2_code;
        dec     <= s2_dec;
        f       <= s2_f;
      end
    end
  end

endmodule
